// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// the load-use FSM state encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Single-operand EX forwarding mux select; MEM result wins over WB, and x0
// or a non-writing producer never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use stalls, data-memory
// wait freezes, branch flushes and stall/flush performance counters.
//
// state    | meaning
// RUN      | normal flow; forwarding, branch flush or first load-use bubble
// LU_STALL | extra load-use bubbles, lu_cnt counts the remaining ones
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              mem_read_e,
    input  logic              pc_src_e,
    input  logic              mem_req_m,
    input  logic              mem_ready_m,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int LC_W = $clog2(LOAD_LAT + 1);

    hz_state_t       state;
    logic [LC_W-1:0] lu_cnt;
    fwd_sel_t        fwd_a;
    fwd_sel_t        fwd_b;
    logic            mem_busy;
    logic            lu_hit;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel         (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel         (fwd_b)
    );

    assign forward_a_e = fwd_a;
    assign forward_b_e = fwd_b;

    assign mem_busy = mem_req_m && !mem_ready_m;
    assign lu_hit   = mem_read_e && reg_write_e && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A memory wait freezes everything and drains WB; a held branch acts
    // once the wait clears because EX is held with it.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (state == LU_STALL) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lu_hit) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            lu_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_d || flush_e) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (!mem_busy) begin
                case (state)
                    RUN: begin
                        if (!pc_src_e && lu_hit && (LOAD_LAT > 1)) begin
                            state  <= LU_STALL;
                            lu_cnt <= LC_W'(LOAD_LAT - 1);
                        end
                    end
                    LU_STALL: begin
                        lu_cnt <= lu_cnt - LC_W'(1);
                        if (lu_cnt == LC_W'(1)) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state  <= RUN;
                        lu_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32I core, sitting beside the datapath between the decode/execute/memory/writeback pipeline registers. It generates EX-stage operand-forwarding selects qualified by write-enable and x0. It detects load-use hazards with a configurable load-to-forward latency, freezes the pipe on a slow data-memory handshake, and issues branch/jump flushes. Two wrapping event counters expose stall and flush activity for performance analysis.

## Interface
Parameters:
- REG_AW, 5, register address width
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..4)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock; reset is asynchronous and active-low, single clock domain
- rst_n  in  1  asynchronous active-low reset
- rs1_d, rs2_d  in  REG_AW  decode-stage source registers
- rs1_e, rs2_e  in  REG_AW  execute-stage source registers
- rd_e, rd_m, rd_w  in  REG_AW  destination registers in EX/MEM/WB
- reg_write_e, reg_write_m, reg_write_w  in  1  destination write enables
- mem_read_e  in  1  instruction in EX is a load
- pc_src_e  in  1  taken branch or jump resolved in EX
- mem_req_m  in  1  data-memory access active in MEM
- mem_ready_m  in  1  data memory accepts/completes access this cycle
- forward_a_e, forward_b_e  out  2  00 regfile, 01 from MEM, 10 from WB
- stall_f, stall_d, stall_e, stall_m  out  1  hold stage register
- flush_d, flush_e, flush_w  out  1  insert bubble into stage register
- stall_cnt, flush_cnt  out  CNT_W  cycles with stall_f high / cycles with flush_d or flush_e high

## Operation
- Forwarding (per operand, combinational): 01 if reg_write_m && rd_m!=0 && rd_m==rs_e; else 10 if reg_write_w && rd_w!=0 && rd_w==rs_e; else 00. MEM has priority over WB.
- mem_busy = mem_req_m && !mem_ready_m. While high: stall_f, stall_d, stall_e, stall_m = 1 and flush_w = 1. All other flushes are 0. FSM and counter are held. pc_src_e is deferred; it acts in the first cycle mem_busy drops.
- lu_hit = mem_read_e && reg_write_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- FSM states RUN, LU_STALL; the counter lu_cnt is a log2(LOAD_LAT+1)-bit down-counter.
- RUN, not mem_busy:
  - If pc_src_e, then flush_d = flush_e = 1 and there is no stall. The branch beats lu_hit because the dependent instruction is discarded.
  - Else if lu_hit, then stall_f = stall_d = 1 and flush_e = 1. If LOAD_LAT>1, go to LU_STALL with lu_cnt = LOAD_LAT-1.
- LU_STALL, not mem_busy:
  - Assert stall_f = stall_d = flush_e = 1 and decrement lu_cnt.
  - When lu_cnt==1, return to RUN next cycle.
  - pc_src_e is ignored, because EX holds a bubble.
- stall_cnt increments every cycle stall_f=1. flush_cnt increments every cycle flush_d||flush_e. Both wrap at 2^CNT_W.
- Reset mid-operation: immediate return to RUN and lu_cnt=0. A pending hazard is not replayed.

## Timing
- Reset values: state RUN, lu_cnt 0, stall_cnt 0, flush_cnt 0.
- All forward, stall and flush outputs are combinational from inputs and current state. They are valid in the same cycle with no registered latency.
- Under reset with all inputs 0, every output is 0.
- Load-use costs exactly LOAD_LAT bubbles: stall_f high for LOAD_LAT consecutive cycles absent mem_busy. mem_busy cycles extend this one-for-one.
- Counters update on the rising clk edge following the counted cycle, so a count is visible one cycle after its event.
- The FSM is the only sequential control. No output depends on a past input except through state/lu_cnt.

## Structure
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - hz_state_t enum: RUN, LU_STALL
- Sub-module fwd_select computes one 2-bit select from (rs_e, rd_m, reg_write_m, rd_w, reg_write_w). It is instantiated twice, for operand A and operand B.
- The FSM, stall/flush logic and counters live in hazard_ctrl.

## Test plan
- rs1_e=5, rd_m=5, rd_w=5, both write enables 1 -> forward_a_e=01. Set reg_write_m=0 -> 10. Set rd_m=rd_w=rs1_e=0 -> 00.
- LOAD_LAT=1: mem_read_e=1, rd_e=7, rs2_d=7 -> one cycle of stall_f=stall_d=flush_e=1, then all low; stall_cnt=1.
- LOAD_LAT=3: same hazard -> stall_f high exactly 3 cycles. Drop mem_ready_m for 2 cycles during the 2nd stall cycle -> stall_f high 5 cycles, with flush_w=1 during the 2 waits.
- pc_src_e=1 together with lu_hit -> flush_d=flush_e=1, stall_f=0, state stays RUN; flush_cnt +1.
- pc_src_e=1 while mem_busy -> flush_d=0 until mem_ready_m=1, then flush_d=flush_e=1 in that cycle.
- Assert rst_n=0 while in LU_STALL with lu_cnt=2 -> all outputs 0 immediately, both counters 0.
